// File: rtl/sum_sched_pkg.sv
// Shared types and elaboration-time helpers for the shared-adder summation scheduler.
package sum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(x)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Result width: enough headroom that N operands of W bits can never overflow.
    function automatic int unsigned calc_ow(input int unsigned n, input int unsigned w);
        return w + clog2(n);
    endfunction

endpackage

// File: rtl/sum_adder_pool.sv
// P lane accumulators, each with one OW-bit adder fed by a buffered operand or a partner lane.
module sum_adder_pool
    import sum_sched_pkg::*;
#(
    parameter int unsigned P  = 5,
    parameter int unsigned W  = 5,
    parameter int unsigned OW = 10,
    parameter int unsigned CW = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic [P-1:0]    en_i,
    input  logic [P-1:0]    sel_partner_i,
    input  logic [P*W-1:0]  lane_op_i,
    input  logic [CW-1:0]   half_i,
    output logic [OW-1:0]   lane0_sum_o
);

    logic [OW-1:0] acc_q [P];
    logic [OW-1:0] acc_d [P];
    logic [OW-1:0] add_w [P];

    always_comb begin
        int unsigned   pidx;
        logic [OW-1:0] partner;
        logic [OW-1:0] addend;
        pidx    = 0;
        partner = '0;
        addend  = '0;
        for (int unsigned j = 0; j < P; j++) begin
            // Partner lane sits half_i lanes above; lanes past the pool see zero.
            pidx    = j + 32'(half_i);
            partner = '0;
            if (pidx < P) begin
                partner = acc_q[pidx];
            end
            addend   = sel_partner_i[j] ? partner : OW'(lane_op_i[j*W +: W]);
            add_w[j] = acc_q[j] + addend;
            if (clr_i) begin
                acc_d[j] = '0;
            end else if (en_i[j]) begin
                acc_d[j] = add_w[j];
            end else begin
                acc_d[j] = acc_q[j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned j = 0; j < P; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < P; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign lane0_sum_o = add_w[0];

endmodule

// File: rtl/sum_sched_ctrl.sv
// Start/done sequencer: lane-accumulate N operands over ceil(N/P) cycles, then tree-reduce
// the P lanes in ceil(log2 P) cycles.
module sum_sched_ctrl
    import sum_sched_pkg::*;
#(
    parameter  int unsigned N  = 30,
    parameter  int unsigned W  = 5,
    parameter  int unsigned P  = 5,
    localparam int unsigned OW = calc_ow(N, W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*W-1:0]  nums,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [OW-1:0]   sum
);

    localparam int unsigned NSteps = ceil_div(N, P);
    localparam int unsigned CW     = clog2(max_u(NSteps, P) + 1);
    localparam int unsigned Pad    = NSteps * P;

    state_e         state_q, state_d;
    logic [N*W-1:0] nums_q;
    logic [CW-1:0]  step_q, step_d;
    logic [CW-1:0]  act_q, act_d;
    logic [OW-1:0]  sum_q, sum_d;

    logic           accept;
    logic           clr;
    logic [P-1:0]   en;
    logic [P-1:0]   sel_partner;
    logic [P*W-1:0] lane_op;
    logic [CW-1:0]  half;
    logic [OW-1:0]  lane0_sum;
    logic [W-1:0]   ops [Pad];

    // Pad the operand list to a whole number of lane rows so the last row indexes safely.
    for (genvar gi = 0; gi < Pad; gi++) begin : g_ops
        if (gi < N) begin : g_real
            assign ops[gi] = nums_q[gi*W +: W];
        end else begin : g_pad
            assign ops[gi] = '0;
        end
    end

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    always_comb begin
        int unsigned idx;
        int unsigned a;
        int unsigned h;
        idx         = 0;
        a           = 0;
        h           = 0;
        state_d     = state_q;
        step_d      = step_q;
        act_d       = act_q;
        sum_d       = sum_q;
        clr         = 1'b0;
        en          = '0;
        sel_partner = '0;
        lane_op     = '0;
        half        = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clr     = 1'b1;
                    step_d  = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                for (int unsigned j = 0; j < P; j++) begin
                    idx = 32'(step_q) * P + j;
                    if (idx < N) begin
                        en[j]             = 1'b1;
                        lane_op[j*W +: W] = ops[idx];
                    end
                end
                if (32'(step_q) == NSteps - 1) begin
                    act_d   = CW'(P);
                    state_d = REDUCE;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            REDUCE: begin
                a    = 32'(act_q);
                h    = (a + 1) / 2;
                half = CW'(h);
                for (int unsigned j = 0; j < P; j++) begin
                    if (j < a / 2) begin
                        en[j]          = 1'b1;
                        sel_partner[j] = 1'b1;
                    end
                end
                act_d = CW'(h);
                // Final pairing: lane 0's adder output is the complete sum.
                if (h == 1) begin
                    sum_d   = lane0_sum;
                    step_d  = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            nums_q  <= '0;
            step_q  <= '0;
            act_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            act_q   <= act_d;
            sum_q   <= sum_d;
            if (accept) begin
                nums_q <= nums;
            end
        end
    end

    sum_adder_pool #(
        .P  (P),
        .W  (W),
        .OW (OW),
        .CW (CW)
    ) u_pool (
        .clk_i         (clk),
        .rst_i         (rst),
        .clr_i         (clr),
        .en_i          (en),
        .sel_partner_i (sel_partner),
        .lane_op_i     (lane_op),
        .half_i        (half),
        .lane0_sum_o   (lane0_sum)
    );

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == ACCUM) || (state_q == REDUCE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;

endmodule

// File: tb/tb_sum_sched_ctrl.sv
// Directed bench: default (30x5b, 5 lanes) instance plus a small (7x4b, 3 lanes) instance.
module tb_sum_sched_ctrl;

    localparam int unsigned TN  = 30;
    localparam int unsigned TW  = 5;
    localparam int unsigned TOW = 10;
    localparam int unsigned SN  = 7;
    localparam int unsigned SW  = 4;
    localparam int unsigned SOW = 7;

    logic              clk;
    logic              rst;
    logic              start;
    logic [TN*TW-1:0]  nums;
    logic              ready, busy, done;
    logic [TOW-1:0]    sum;

    logic              start_s;
    logic [SN*SW-1:0]  nums_s;
    logic              ready_s, busy_s, done_s;
    logic [SOW-1:0]    sum_s;

    int n_checks;
    int n_fail;

    sum_sched_ctrl u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .nums  (nums),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    sum_sched_ctrl #(
        .N (SN),
        .W (SW),
        .P (3)
    ) u_dut_small (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .nums  (nums_s),
        .ready (ready_s),
        .busy  (busy_s),
        .done  (done_s),
        .sum   (sum_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [TN*TW-1:0] fill_all(input logic [TW-1:0] v);
        logic [TN*TW-1:0] r;
        for (int i = 0; i < TN; i++) r[i*TW +: TW] = v;
        return r;
    endfunction

    function automatic logic [TN*TW-1:0] ramp();
        logic [TN*TW-1:0] r;
        for (int i = 0; i < TN; i++) r[i*TW +: TW] = TW'(i + 1);
        return r;
    endfunction

    // Accept one operation and count cycles until done, bounded at 30.
    task automatic run_big(input logic [TN*TW-1:0] v, output int lat);
        nums  = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first_c;
        int nd;
        int dcyc [4];
        logic [TOW-1:0] dsum [4];
        logic [TOW-1:0] first_sum;
        logic sel;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        nums     = '0;
        start_s  = 1'b0;
        nums_s   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);

        // All 31: latency 9, sum 930.
        nums  = fill_all(5'd31);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        check("run_ready", 32'(ready), 32'd0);
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("all31_latency", 32'(lat), 32'd9);
        check("all31_sum", 32'(sum), 32'd930);
        tick();
        check("all31_done_pulse", 32'(done), 32'd0);
        check("all31_ready_after", 32'(ready), 32'd1);
        check("all31_sum_held", 32'(sum), 32'd930);

        run_big(ramp(), lat);
        check("ramp_latency", 32'(lat), 32'd9);
        check("ramp_sum", 32'(sum), 32'd465);
        tick();

        // start pulses mid-run with new operands must be ignored.
        nums  = fill_all(5'd31);
        start = 1'b1;
        tick();
        pulses    = 0;
        first_c   = 0;
        first_sum = '0;
        for (int c = 1; c <= 14; c++) begin
            start = (c == 2) || (c == 5);
            nums  = fill_all(5'd1);
            tick();
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_c   = c;
                    first_sum = sum;
                end
            end
        end
        start = 1'b0;
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_done_cycle", 32'(first_c), 32'd9);
        check("ignore_sum", 32'(first_sum), 32'd930);

        // start held high, operand sets alternate on each done.
        nd    = 0;
        sel   = 1'b0;
        nums  = fill_all(5'd1);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done && nd < 4) begin
                dcyc[nd] = c;
                dsum[nd] = sum;
                nd++;
                sel  = ~sel;
                nums = sel ? fill_all(5'd2) : fill_all(5'd1);
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b_cycle0", 32'(dcyc[0]), 32'd10);
            check("b2b_cycle1", 32'(dcyc[1]), 32'd20);
            check("b2b_cycle2", 32'(dcyc[2]), 32'd30);
            check("b2b_sum0", 32'(dsum[0]), 32'd30);
            check("b2b_sum1", 32'(dsum[1]), 32'd60);
            check("b2b_sum2", 32'(dsum[2]), 32'd30);
        end
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Reset during ACCUM aborts without exposing a result.
        nums  = fill_all(5'd31);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_big(ramp(), lat);
        check("abort_fresh_latency", 32'(lat), 32'd9);
        check("abort_fresh_sum", 32'(sum), 32'd465);

        // rst and start together from DONE: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        nums  = fill_all(5'd1);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_sum", 32'(sum), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        tick();
        check("rst_start_stays_idle", 32'(busy), 32'd0);

        // Small configuration: 7 operands of 15, 3 lanes.
        for (int i = 0; i < SN; i++) nums_s[i*SW +: SW] = 4'd15;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 30) begin
            tick();
            lat++;
        end
        check("small_latency", 32'(lat), 32'd5);
        check("small_sum", 32'(sum_s), 32'd105);
        tick();
        check("small_done_pulse", 32'(done_s), 32'd0);
        check("small_ready", 32'(ready_s), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
